// File: rtl/wishbone_classic_master.sv
// Wishbone classic (B3) single-transfer initiator.
// Accepts one request at a time on a valid/ready stream, runs a single
// Wishbone read or write cycle, and returns read data plus an error flag on a
// valid/ready response stream. A programmable timeout ends cycles that the
// slave never acknowledges.
//
// Ports
//   clk, rstn                 clock (rising edge), synchronous active-low reset
//   s_req_valid/ready         request handshake
//   s_req_we/addr/data/sel    request payload (write enable, byte address, write data, byte selects)
//   m_rsp_valid/ready         response handshake
//   m_rsp_data/err            read data (0 for writes/errors), error flag (slave err or timeout)
//   m_wb_cyc/stb/we           Wishbone cycle, strobe, write enable
//   m_wb_addr/data_o/sel      Wishbone address, write data, byte selects
//   m_wb_ack/err/data_i       Wishbone acknowledge, error, read data
module wishbone_classic_master #(
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned BUS_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       s_req_valid,
    output logic                       s_req_ready,
    input  logic                       s_req_we,
    input  logic [ADDRESS_WIDTH-1:0]   s_req_addr,
    input  logic [BUS_WIDTH*8-1:0]     s_req_data,
    input  logic [BUS_WIDTH-1:0]       s_req_sel,
    output logic                       m_rsp_valid,
    input  logic                       m_rsp_ready,
    output logic [BUS_WIDTH*8-1:0]     m_rsp_data,
    output logic                       m_rsp_err,
    output logic                       m_wb_cyc,
    output logic                       m_wb_stb,
    output logic                       m_wb_we,
    output logic [ADDRESS_WIDTH-1:0]   m_wb_addr,
    output logic [BUS_WIDTH*8-1:0]     m_wb_data_o,
    output logic [BUS_WIDTH-1:0]       m_wb_sel,
    input  logic                       m_wb_ack,
    input  logic                       m_wb_err,
    input  logic [BUS_WIDTH*8-1:0]     m_wb_data_i
);

    localparam int unsigned DATA_W = BUS_WIDTH * 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
    // Counter value seen on the last cycle strobe is allowed to stay high.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                     r_state,     w_state_nxt;
    logic [CNT_W-1:0]           r_cnt,       w_cnt_nxt;
    logic                       r_req_ready, w_req_ready_nxt;
    logic                       r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]          r_rsp_data,  w_rsp_data_nxt;
    logic                       r_rsp_err,   w_rsp_err_nxt;
    logic                       r_cyc,       w_cyc_nxt;
    logic                       r_stb,       w_stb_nxt;
    logic                       r_we,        w_we_nxt;
    logic [ADDRESS_WIDTH-1:0]   r_addr,      w_addr_nxt;
    logic [DATA_W-1:0]          r_wdata,     w_wdata_nxt;
    logic [BUS_WIDTH-1:0]       r_sel,       w_sel_nxt;
    logic                       w_timeout;

    assign w_timeout = TO_EN && (r_cnt == TO_LAST);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_sel       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_cyc       <= w_cyc_nxt;
            r_stb       <= w_stb_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_sel       <= w_sel_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = r_rsp_err;
        w_cyc_nxt       = r_cyc;
        w_stb_nxt       = r_stb;
        w_we_nxt        = r_we;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_sel_nxt       = r_sel;

        case (r_state)
            ST_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (s_req_valid) begin
                    w_cyc_nxt       = 1'b1;
                    w_stb_nxt       = 1'b1;
                    w_we_nxt        = s_req_we;
                    w_addr_nxt      = s_req_addr;
                    w_wdata_nxt     = s_req_data;
                    w_sel_nxt       = s_req_sel;
                    w_req_ready_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_BUS;
                end
            end

            ST_BUS: begin
                // err has priority over ack; ack in the final cycle beats the timeout.
                if (m_wb_err || m_wb_ack || w_timeout) begin
                    w_cyc_nxt       = 1'b0;
                    w_stb_nxt       = 1'b0;
                    w_we_nxt        = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_RESP;
                    if (!m_wb_err && m_wb_ack) begin
                        w_rsp_err_nxt  = 1'b0;
                        w_rsp_data_nxt = r_we ? '0 : m_wb_data_i;
                    end else begin
                        w_rsp_err_nxt  = 1'b1;
                        w_rsp_data_nxt = '0;
                    end
                end else if (TO_EN) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (m_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_req_ready_nxt = 1'b1;
                w_rsp_valid_nxt = 1'b0;
                w_cyc_nxt       = 1'b0;
                w_stb_nxt       = 1'b0;
            end
        endcase
    end

    assign s_req_ready = r_req_ready;
    assign m_rsp_valid = r_rsp_valid;
    assign m_rsp_data  = r_rsp_data;
    assign m_rsp_err   = r_rsp_err;
    assign m_wb_cyc    = r_cyc;
    assign m_wb_stb    = r_stb;
    assign m_wb_we     = r_we;
    assign m_wb_addr   = r_addr;
    assign m_wb_data_o = r_wdata;
    assign m_wb_sel    = r_sel;

endmodule

// File: tb/tb_wishbone_classic_master.sv
// Self-checking bench for wishbone_classic_master: a slave model plays out a
// per-transaction plan, a reference model predicts each response and strobe
// length, and a monitor compares responses as they are consumed.
`timescale 1ns/1ps
module tb_wishbone_classic_master;

    localparam int unsigned AW = 16;
    localparam int unsigned BW = 4;
    localparam int unsigned DW = BW * 8;
    localparam int          TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn = 1'b0;
    logic          s_req_valid = 1'b0;
    logic          s_req_ready;
    logic          s_req_we = 1'b0;
    logic [AW-1:0] s_req_addr = '0;
    logic [DW-1:0] s_req_data = '0;
    logic [BW-1:0] s_req_sel = '0;
    logic          m_rsp_valid;
    logic          m_rsp_ready = 1'b0;
    logic [DW-1:0] m_rsp_data;
    logic          m_rsp_err;
    logic          m_wb_cyc, m_wb_stb, m_wb_we;
    logic [AW-1:0] m_wb_addr;
    logic [DW-1:0] m_wb_data_o;
    logic [BW-1:0] m_wb_sel;
    logic          m_wb_ack, m_wb_err;
    logic [DW-1:0] m_wb_data_i = '0;
    logic          sl_ack = 1'b0, sl_err = 1'b0, ack_force = 1'b0;

    assign m_wb_ack = sl_ack | ack_force;
    assign m_wb_err = sl_err;

    wishbone_classic_master #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .rstn(rstn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
        .s_req_addr(s_req_addr), .s_req_data(s_req_data), .s_req_sel(s_req_sel),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data),
        .m_rsp_err(m_rsp_err), .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we),
        .m_wb_addr(m_wb_addr), .m_wb_data_o(m_wb_data_o), .m_wb_sel(m_wb_sel),
        .m_wb_ack(m_wb_ack), .m_wb_err(m_wb_err), .m_wb_data_i(m_wb_data_i)
    );

    // Second instance with the timeout disabled.
    logic          z_req_valid = 1'b0, z_req_ready, z_rsp_valid, z_rsp_ready = 1'b0, z_rsp_err;
    logic [DW-1:0] z_rsp_data, z_wdata;
    logic          z_cyc, z_stb, z_we, z_ack = 1'b0;
    logic [AW-1:0] z_addr;
    logic [BW-1:0] z_sel;
    logic [DW-1:0] z_data_i = 32'h5A5A_1234;

    wishbone_classic_master #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(0)) u_dut0 (
        .clk(clk), .rstn(rstn),
        .s_req_valid(z_req_valid), .s_req_ready(z_req_ready), .s_req_we(1'b0),
        .s_req_addr(16'h0010), .s_req_data(32'h0), .s_req_sel(4'hF),
        .m_rsp_valid(z_rsp_valid), .m_rsp_ready(z_rsp_ready), .m_rsp_data(z_rsp_data),
        .m_rsp_err(z_rsp_err), .m_wb_cyc(z_cyc), .m_wb_stb(z_stb), .m_wb_we(z_we),
        .m_wb_addr(z_addr), .m_wb_data_o(z_wdata), .m_wb_sel(z_sel),
        .m_wb_ack(z_ack), .m_wb_err(1'b0), .m_wb_data_i(z_data_i)
    );

    // kind: 0 ack, 1 err, 2 err+ack, 3 silent slave. delay: cycles of stb before the reply.
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] sel;
        int            delay;
        int            kind;
        logic [DW-1:0] rdata;
        int            exp_stb;
    } plan_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    plan_t plan_q[$];
    rsp_t  rsp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    rdy_mode = 0;   // 0 random, 1 hold low, 2 hold high

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: reply arrives after delay+1 strobe cycles unless that exceeds the timeout.
    function automatic void model(input plan_t p, output rsp_t r, output int stb_cycles);
        if (p.kind == 3 || p.delay >= TO) begin
            r.data = '0; r.err = 1'b1; stb_cycles = TO;
        end else begin
            stb_cycles = p.delay + 1;
            r.err  = (p.kind != 0);
            r.data = (p.kind == 0 && !p.we) ? p.rdata : '0;
        end
    endfunction

    function automatic plan_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [BW-1:0] s, input int dly, input int kind,
                                 input logic [DW-1:0] rd);
        plan_t p;
        p.we = we; p.addr = a; p.data = d; p.sel = s;
        p.delay = dly; p.kind = kind; p.rdata = rd; p.exp_stb = 0;
        return p;
    endfunction

    task automatic send(input plan_t p, input bit track);
        rsp_t r;
        int   s;
        int   w;
        bit   ok;
        model(p, r, s);
        p.exp_stb = track ? s : -1;
        plan_q.push_back(p);
        if (track) rsp_q.push_back(r);
        @(negedge clk);
        s_req_valid = 1'b1; s_req_we = p.we; s_req_addr = p.addr;
        s_req_data = p.data; s_req_sel = p.sel;
        w = 0; ok = 1'b0;
        while (!ok) begin
            ok = s_req_ready;
            @(posedge clk);
            if (!ok) begin
                w++;
                if (w > 300) begin
                    chk("req_accept_timeout", 64'd0, 64'd1);
                    break;
                end
                @(negedge clk);
            end
        end
        @(negedge clk);
        s_req_valid = 1'b0; s_req_we = 1'($urandom); s_req_addr = AW'($urandom);
        s_req_data = $urandom; s_req_sel = BW'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while ((rsp_q.size() != 0 || plan_q.size() != 0 || m_rsp_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    // Slave model: replies per plan, checks payload, stability and strobe length.
    plan_t cur;
    bit    active = 1'b0, unstable = 1'b0, prev_cyc = 1'b0;
    int    scnt = 0;
    always @(negedge clk) begin
        sl_ack = 1'b0; sl_err = 1'b0;
        m_wb_data_i = $urandom;
        if (m_wb_stb === 1'b1) begin
            if (!active) begin
                chk("cyc_gap_before_txn", 64'(prev_cyc), 64'd0);
                if (plan_q.size() == 0) begin
                    chk("unexpected_stb", 64'd1, 64'd0);
                    cur = mk(1'b0, '0, '0, '0, 0, 3, '0);
                    cur.exp_stb = -1;
                end else begin
                    cur = plan_q.pop_front();
                end
                active = 1'b1; scnt = 0; unstable = 1'b0;
                chk("wb_we",   64'(m_wb_we),     64'(cur.we));
                chk("wb_addr", 64'(m_wb_addr),   64'(cur.addr));
                chk("wb_data", 64'(m_wb_data_o), 64'(cur.data));
                chk("wb_sel",  64'(m_wb_sel),    64'(cur.sel));
            end
            if (m_wb_cyc !== 1'b1 || m_wb_we !== cur.we || m_wb_addr !== cur.addr ||
                m_wb_data_o !== cur.data || m_wb_sel !== cur.sel)
                unstable = 1'b1;
            scnt++;
            if (cur.kind != 3 && scnt == cur.delay + 1) begin
                m_wb_data_i = cur.rdata;
                sl_ack = (cur.kind == 0 || cur.kind == 2);
                sl_err = (cur.kind == 1 || cur.kind == 2);
            end
        end else begin
            if (active) begin
                if (cur.exp_stb >= 0) begin
                    chk("stb_cycles", 64'(scnt), 64'(cur.exp_stb));
                    chk("bus_fields_stable", 64'(unstable), 64'd0);
                    chk("cyc_drop_with_stb", 64'(m_wb_cyc), 64'd0);
                end
                active = 1'b0;
            end
            // Stray replies outside a bus cycle must be ignored.
            if (rstn && ack_force == 1'b0 && ($urandom % 6) == 0) begin
                sl_ack = 1'($urandom);
                sl_err = 1'($urandom);
            end
        end
        prev_cyc = (m_wb_cyc === 1'b1);
    end

    // Response monitor: picks ready, checks hold during stalls, compares on handshake.
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_err;
    rsp_t          exp_r;
    bit            rdy;
    always @(negedge clk) begin
        rdy = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : (($urandom % 3) != 0);
        m_rsp_ready = rdy;
        if (prev_stall && rstn) begin
            chk("rsp_hold_valid", 64'(m_rsp_valid), 64'd1);
            chk("rsp_hold_data",  64'(m_rsp_data),  64'(prev_data));
            chk("rsp_hold_err",   64'(m_rsp_err),   64'(prev_err));
        end
        if (m_rsp_valid === 1'b1) begin
            chk("no_cyc_during_rsp",   64'(m_wb_cyc),    64'd0);
            chk("req_ready_during_rsp", 64'(s_req_ready), 64'd0);
            if (rdy) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    exp_r = rsp_q.pop_front();
                    chk("rsp_data", 64'(m_rsp_data), 64'(exp_r.data));
                    chk("rsp_err",  64'(m_rsp_err),  64'(exp_r.err));
                end
            end
        end
        prev_stall = (m_rsp_valid === 1'b1) && !rdy;
        prev_data  = m_rsp_data;
        prev_err   = m_rsp_err;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, d, n;
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(s_req_ready), 64'd1);
        chk("reset_cyc",       64'(m_wb_cyc),    64'd0);
        chk("reset_stb",       64'(m_wb_stb),    64'd0);
        chk("reset_we",        64'(m_wb_we),     64'd0);
        chk("reset_addr",      64'(m_wb_addr),   64'd0);
        chk("reset_wdata",     64'(m_wb_data_o), 64'd0);
        chk("reset_sel",       64'(m_wb_sel),    64'd0);
        chk("reset_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("reset_rsp_data",  64'(m_rsp_data),  64'd0);
        chk("reset_rsp_err",   64'(m_rsp_err),   64'd0);
        rstn = 1'b1;

        // Write acked one cycle after strobe, then a read returning data.
        send(mk(1'b1, 16'h0004, 32'hAAAA_0000, 4'hF, 1, 0, 32'hDEAD_BEEF), 1'b1);
        drain();
        send(mk(1'b0, 16'h0008, 32'h0, 4'hF, 0, 0, 32'h0000_0012), 1'b1);
        drain();

        // Timeout boundaries: silent slave, ack on the last allowed cycle, ack one too late.
        send(mk(1'b0, 16'h000C, 32'h0, 4'hF, 0, 3, 32'h1111_1111), 1'b1);
        drain();
        send(mk(1'b0, 16'h0010, 32'h0, 4'hF, TO - 1, 0, 32'h2222_2222), 1'b1);
        drain();
        send(mk(1'b0, 16'h0014, 32'h0, 4'hF, TO, 0, 32'h3333_3333), 1'b1);
        drain();

        // err together with ack, response stalled for five cycles.
        rdy_mode = 1;
        send(mk(1'b0, 16'h0018, 32'h0, 4'h3, 2, 2, 32'h4444_4444), 1'b1);
        n = 0;
        while (m_rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("rsp_valid_seen", 64'(m_rsp_valid), 64'd1);
        repeat (5) @(negedge clk);
        rdy_mode = 2;
        drain();

        // Reset while the bus cycle is open; a later ack must be ignored.
        send(mk(1'b1, 16'h0020, 32'h5555_5555, 4'hF, 0, 3, 32'h0), 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("rst_mid_cyc",       64'(m_wb_cyc),    64'd0);
        chk("rst_mid_stb",       64'(m_wb_stb),    64'd0);
        chk("rst_mid_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("rst_mid_req_ready", 64'(s_req_ready), 64'd1);
        ack_force = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("late_ack_rsp_valid", 64'(m_rsp_valid), 64'd0);
            chk("late_ack_cyc",       64'(m_wb_cyc),    64'd0);
        end
        ack_force = 1'b0;
        drain();

        // Four back-to-back writes in order.
        for (int i = 0; i < 4; i++)
            send(mk(1'b1, AW'(16'h0100 + 4 * i), 32'hAAAA_0000 + 32'(i), 4'hF,
                    int'($urandom_range(0, 3)), 0, $urandom), 1'b1);
        drain();

        // Random traffic with random response back-pressure.
        rdy_mode = 0;
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom % 10);
            k = (k < 6) ? 0 : (k == 6) ? 1 : (k == 7) ? 2 : 3;
            d = int'($urandom_range(0, 10));
            send(mk(1'($urandom), AW'($urandom), $urandom, BW'($urandom), d, k, $urandom), 1'b1);
        end
        drain();
        rdy_mode = 2;

        // Timeout disabled: strobe stays up until the slave answers.
        @(negedge clk);
        z_req_valid = 1'b1; z_rsp_ready = 1'b1;
        @(negedge clk);
        z_req_valid = 1'b0;
        n = 0;
        repeat (40) begin
            if (z_stb === 1'b1) n++;
            @(negedge clk);
        end
        chk("no_timeout_stb_cycles", 64'(n), 64'd40);
        chk("no_timeout_no_rsp",     64'(z_rsp_valid), 64'd0);
        z_ack = 1'b1;
        @(negedge clk);
        z_ack = 1'b0;
        chk("no_timeout_rsp_valid", 64'(z_rsp_valid), 64'd1);
        chk("no_timeout_rsp_err",   64'(z_rsp_err),   64'd0);
        chk("no_timeout_rsp_data",  64'(z_rsp_data),  64'h5A5A_1234);
        chk("no_timeout_stb_drop",  64'(z_stb),       64'd0);
        @(negedge clk);
        chk("no_timeout_rsp_done",  64'(z_rsp_valid), 64'd0);
        chk("no_timeout_ready",     64'(z_req_ready), 64'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
